mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the shared memory; legal addresses are 0..DEPTH-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 p0_req_valid  input  1  port 0 (instruction fetch, read-only) request valid.
REQ-005 p0_req_ready  output  1  port 0 request accepted this cycle.
REQ-006 p0_addr  input  32  port 0 word address.
REQ-007 p1_req_valid  input  1  port 1 (data load/store) request valid.
REQ-008 p1_req_ready  output  1  port 1 request accepted this cycle.
REQ-009 p1_we  input  1  port 1 write request (1) or read request (0).
REQ-010 p1_addr  input  32  port 1 word address.
REQ-011 p1_wdata  input  32  port 1 write data.
REQ-012 p0_resp_valid  output  1  one-cycle response pulse for port 0.
REQ-013 p1_resp_valid  output  1  one-cycle response pulse for port 1.
REQ-014 resp_rdata  output  32  response read data, valid only while a resp_valid is high.
REQ-015 resp_err  output  1  response error flag (address out of range), valid with resp_valid.
REQ-016 mem_write_enable  output  1  to memory write_enable.
REQ-017 mem_address  output  32  to memory address.
REQ-018 mem_write_data  output  32  to memory write_data.
REQ-019 mem_read_data  input  32  from memory; registered, valid one clock after the address is sampled.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on acceptance, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-021 Requests are accepted only in IDLE; px_req_ready is high only in IDLE, for the granted port, while that port's valid is high; at most one ready per cycle.
REQ-022 On acceptance, the port id, address, we (0 for port 0) and wdata are registered; request inputs are ignored outside IDLE.
REQ-023 In ACCESS, mem_address, mem_write_data and mem_write_enable are driven from the registered request; mem_write_enable is high only for an in-range write.
REQ-024 In RESP, the granted port's resp_valid is high for exactly one cycle; resp_rdata = mem_read_data for in-range requests, 0 otherwise.
REQ-025 A write response carries the pre-write contents of the addressed word in resp_rdata.
REQ-026 Address >= DEPTH: no memory write, resp_err = 1, resp_rdata = 0, same timing; otherwise resp_err = 0.
REQ-027 Latency is fixed: request accepted in cycle N, response in cycle N+2, next acceptance no earlier than N+3.
REQ-028 Outside ACCESS, mem_write_enable = 0 and mem_address/mem_write_data hold their last values.
REQ-029 A requester holds valid and request fields stable until ready; dropping valid before ready is legal and withdraws the request.

Reset
REQ-030 While rst_n = 0: state IDLE, all ready/resp_valid/resp_err/mem_write_enable = 0, resp_rdata = 0, mem_address = 0, mem_write_data = 0, last-grant register = port 1.
REQ-031 Reset asserted in ACCESS or RESP aborts the transaction immediately: no resp_valid is issued and mem_write_enable falls without waiting for clk.

Configuration
REQ-032 Macro MEM_ARBITER_RR_EN defined: round-robin arbitration; with both ports valid in IDLE, the port not granted last wins; a sole requester always wins; the last-grant register updates on every acceptance.
REQ-033 MEM_ARBITER_RR_EN undefined: fixed priority, port 1 always wins over port 0; no last-grant register is implemented.

Verification
REQ-034 Reset, p1 write addr 0x05 data 0xDEADBEEF -> p1_req_ready in cycle 0, mem_write_enable=1 in cycle 1, p1_resp_valid in cycle 2 with resp_err=0.
REQ-035 Then p0 read addr 0x05 -> p0_resp_valid two cycles after acceptance, resp_rdata=0xDEADBEEF.
REQ-036 Both ports valid continuously with MEM_ARBITER_RR_EN -> grants alternate p0,p1,p0,p1 (p0 first after reset), one acceptance every 3 cycles; without macro -> p1 every time, p0 starved.
REQ-037 p1 write addr 0x100 (DEPTH=256) -> mem_write_enable stays 0, p1_resp_valid with resp_err=1, resp_rdata=0; subsequent read of 0x00 returns unchanged contents.
REQ-038 rst_n pulled low in ACCESS of a write -> no resp_valid, mem_write_enable=0 at once, FSM in IDLE and first request after release accepted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port (p0, read-only) and a
// data load/store port (p1) onto one single-port synchronous memory.
// Every transaction takes IDLE -> ACCESS -> RESP. Requests are accepted only
// in IDLE, the memory is driven in ACCESS, and the response pulses in RESP.
// Optional feature macro: MEM_ARBITER_RR_EN selects round-robin arbitration.
// Without it, port 1 has fixed priority.
module mem_arbiter #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_addr,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_resp_valid,
  output logic        p1_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        port_q, port_d;          // owner of the current transaction, 1 = port 1
  logic        err_q, err_d;            // current transaction is out of range
  logic        p0_resp_valid_q, p0_resp_valid_d;
  logic        p1_resp_valid_q, p1_resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        gnt1;
  logic        accept;
  logic [31:0] sel_addr;
  logic        sel_in_range;

`ifdef MEM_ARBITER_RR_EN
  logic        last_grant_q, last_grant_d;  // 1 = port 1 was granted last

  // Round robin: on contention the port not granted last wins; a sole requester always wins
  always_comb begin
    gnt1 = p1_req_valid & (~p0_req_valid | ~last_grant_q);
  end
`else
  // Fixed priority: port 1 wins whenever it requests
  always_comb begin
    gnt1 = p1_req_valid;
  end
`endif

  // Readies are gated by rst_n so nothing is handshaked while reset is held
  assign accept       = rst_n & (state_q == IDLE) & (p0_req_valid | p1_req_valid);
  assign p1_req_ready = accept & gnt1;
  assign p0_req_ready = accept & ~gnt1;
  assign sel_addr     = gnt1 ? p1_addr : p0_addr;
  assign sel_in_range = (sel_addr < 32'(DEPTH));

  // Next-state and next-output logic for the three-phase transaction
  always_comb begin
    state_d         = state_q;
    port_d          = port_q;
    err_d           = err_q;
    p0_resp_valid_d = 1'b0;
    p1_resp_valid_d = 1'b0;
    resp_err_d      = 1'b0;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
`ifdef MEM_ARBITER_RR_EN
    last_grant_d    = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = ACCESS;
          port_d     = gnt1;
          err_d      = ~sel_in_range;
          mem_addr_d = sel_addr;
          if (gnt1) begin
            mem_wdata_d = p1_wdata;
          end
          // Out-of-range writes never reach the memory
          mem_we_d   = gnt1 & p1_we & sel_in_range;
`ifdef MEM_ARBITER_RR_EN
          last_grant_d = gnt1;
`endif
        end
      end
      ACCESS: begin
        state_d         = RESP;
        p0_resp_valid_d = ~port_q;
        p1_resp_valid_d = port_q;
        resp_err_d      = err_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      port_q          <= 1'b0;
      err_q           <= 1'b0;
      p0_resp_valid_q <= 1'b0;
      p1_resp_valid_q <= 1'b0;
      resp_err_q      <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
`ifdef MEM_ARBITER_RR_EN
      last_grant_q    <= 1'b1;
`endif
    end else begin
      state_q         <= state_d;
      port_q          <= port_d;
      err_q           <= err_d;
      p0_resp_valid_q <= p0_resp_valid_d;
      p1_resp_valid_q <= p1_resp_valid_d;
      resp_err_q      <= resp_err_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
`ifdef MEM_ARBITER_RR_EN
      last_grant_q    <= last_grant_d;
`endif
    end
  end

  assign p0_resp_valid    = p0_resp_valid_q;
  assign p1_resp_valid    = p1_resp_valid_q;
  assign resp_err         = resp_err_q;
  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  // Memory read data lands in RESP; it is forced to zero for out-of-range requests
  assign resp_rdata = ((p0_resp_valid_q | p1_resp_valid_q) & ~resp_err_q) ? mem_read_data : 32'd0;

endmodule
